// File: rtl/write_back_stage.sv
// Write-back stage: 2-entry skid buffer feeding the register-file write port,
// with branch/jump resolution at retirement, flush, stall hold and a retire counter.
module write_back_stage #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 6,
    parameter int PC_W             = 32,
    parameter int CNT_W            = 16,
    parameter int ZERO_REG_DISCARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_we,
    input  logic [ADDR_W-1:0] in_reg_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_jump_type,
    input  logic              in_cond_src,
    input  logic              in_branch_cond,
    input  logic              in_cond_flag,
    input  logic [PC_W-1:0]   in_target,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_target,
    output logic [CNT_W-1:0]  retired_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              reg_we;
        logic [ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        jump_type;
        logic              cond;
        logic              branch_cond;
        logic [PC_W-1:0]   target;
    } entry_t;

    localparam logic DISCARD_ZERO = (ZERO_REG_DISCARD != 0);

    state_t            state_q, state_d;
    entry_t            s0_q, s0_d;
    entry_t            s1_q, s1_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]   redirect_target_q, redirect_target_d;
    logic [CNT_W-1:0]  count_q, count_d;

    entry_t in_entry;
    logic   s0_valid;
    logic   accept;
    logic   advance;
    logic   retire;
    logic   taken;

    // The branch condition is resolved once, at capture, and travels with the entry.
    always_comb begin
        in_entry.reg_we      = in_reg_we;
        in_entry.reg_addr    = in_reg_addr;
        in_entry.data        = in_data;
        in_entry.jump_type   = in_jump_type;
        in_entry.cond        = in_cond_src ? in_cond_flag : (in_data == '0);
        in_entry.branch_cond = in_branch_cond;
        in_entry.target      = in_target;
    end

    // in_ready depends only on registered occupancy; reset gates it off while held.
    assign in_ready = reset & (state_q != FULL);
    assign s0_valid = (state_q != EMPTY);
    assign accept   = in_valid & in_ready;
    assign advance  = rf_ready & ~stall & ~flush;
    assign retire   = s0_valid & advance;
    assign taken    = s0_q.jump_type[1] |
                      ((s0_q.jump_type == 2'b01) & (s0_q.cond == s0_q.branch_cond));

    assign rf_we           = retire & s0_q.reg_we & ~(DISCARD_ZERO & (s0_q.reg_addr == '0));
    assign rf_addr         = s0_q.reg_addr;
    assign rf_data         = s0_q.data;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_target = redirect_target_q;
    assign retired_count   = count_q;

    always_comb begin
        state_d           = state_q;
        s0_d              = s0_q;
        s1_d              = s1_q;
        redirect_valid_d  = retire & taken;
        redirect_target_d = (retire & taken) ? s0_q.target : redirect_target_q;
        count_d           = count_q + {{(CNT_W-1){1'b0}}, retire};

        if (flush) begin
            state_d = EMPTY;
        end else if (retire & taken) begin
            // A taken redirect squashes everything younger, including a same-cycle accept.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        s0_d    = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (retire && accept) begin
                        s0_d = in_entry;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        s1_d    = in_entry;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (retire) begin
                        s0_d    = s1_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= EMPTY;
            s0_q              <= '0;
            s1_q              <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_target_q <= '0;
            count_q           <= '0;
        end else begin
            state_q           <= state_d;
            s0_q              <= s0_d;
            s1_q              <= s1_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_target_q <= redirect_target_d;
            count_q           <= count_d;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: directed entries push expected writes and
// redirects; a negedge monitor pops and compares whatever the DUT presents.
module tb_write_back_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_we;
    logic [5:0]  in_reg_addr;
    logic [31:0] in_data;
    logic [1:0]  in_jump_type;
    logic        in_cond_src;
    logic        in_branch_cond;
    logic        in_cond_flag;
    logic [31:0] in_target;
    logic        rf_ready;
    logic        rf_we;
    logic [5:0]  rf_addr;
    logic [31:0] rf_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [15:0] retired_count;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb_wr[$];
    logic [31:0] sb_redir[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          exp_cnt    = 0;

    write_back_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_reg_we       (in_reg_we),
        .in_reg_addr     (in_reg_addr),
        .in_data         (in_data),
        .in_jump_type    (in_jump_type),
        .in_cond_src     (in_cond_src),
        .in_branch_cond  (in_branch_cond),
        .in_cond_flag    (in_cond_flag),
        .in_target       (in_target),
        .rf_ready        (rf_ready),
        .rf_we           (rf_we),
        .rf_addr         (rf_addr),
        .rf_data         (rf_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("check %s = %0h ok", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d,
                       input logic [1:0] jt, input logic cs, input logic bc, input logic fl,
                       input logic [31:0] tg);
        in_valid       = v;
        in_reg_we      = we;
        in_reg_addr    = a;
        in_data        = d;
        in_jump_type   = jt;
        in_cond_src    = cs;
        in_branch_cond = bc;
        in_cond_flag   = fl;
        in_target      = tg;
    endtask

    task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb_wr.push_back(e);
    endtask

    // Monitor: every write strobe and redirect pulse must match the next expectation.
    always @(negedge clk) begin
        wr_t e;
        if (rf_we === 1'b1) begin
            compared++;
            if (sb_wr.size() == 0) begin
                mismatched++;
                $display("FAIL rf_write: got addr %0h data %0h expected no write", rf_addr, rf_data);
            end else begin
                e = sb_wr.pop_front();
                if (rf_addr !== e.a || rf_data !== e.d) begin
                    mismatched++;
                    $display("FAIL rf_write: got addr %0h data %0h expected addr %0h data %0h",
                             rf_addr, rf_data, e.a, e.d);
                end else begin
                    $display("write addr %0h data %0h ok", rf_addr, rf_data);
                end
            end
        end
        if (redirect_valid === 1'b1) begin
            compared++;
            if (sb_redir.size() == 0) begin
                mismatched++;
                $display("FAIL redirect: got target %0h expected no redirect", redirect_target);
            end else if (redirect_target !== sb_redir[0]) begin
                mismatched++;
                $display("FAIL redirect: got target %0h expected %0h", redirect_target, sb_redir[0]);
                void'(sb_redir.pop_front());
            end else begin
                $display("redirect target %0h ok", redirect_target);
                void'(sb_redir.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        rf_ready = 1'b0;
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Reset state while held
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_target", redirect_target, 0);
        chk("rst_count", retired_count, 0);
        step();
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Stream 4 entries at full rate
        rf_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            put(1, 1, 6'(i), 32'(i * 16), 2'b00, 0, 0, 0, 0);
            expect_wr(6'(i), 32'(i * 16));
            chk("stream_in_ready", in_ready, 1);
            step();
        end
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step();
        exp_cnt += 4;
        chk("stream_count", retired_count, 16'(exp_cnt));

        // Backpressure: fill to FULL, then drain in order
        rf_ready = 1'b0;
        put(1, 1, 1, 32'h11, 2'b00, 0, 0, 0, 0);
        expect_wr(1, 32'h11);
        step();
        put(1, 1, 2, 32'h22, 2'b00, 0, 0, 0, 0);
        expect_wr(2, 32'h22);
        step();
        put(1, 1, 3, 32'h33, 2'b00, 0, 0, 0, 0);
        chk("full_in_ready", in_ready, 0);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("full_hold_in_ready", in_ready, 0);
        rf_ready = 1'b1;
        step();
        step();
        step();
        exp_cnt += 2;
        chk("drain_count", retired_count, 16'(exp_cnt));

        // Taken branch with S1 occupied: S1 never writes
        rf_ready = 1'b0;
        put(1, 1, 8, 32'h0, 2'b01, 0, 1, 0, 32'h400);
        expect_wr(8, 32'h0);
        step();
        put(1, 1, 9, 32'h99, 2'b00, 0, 0, 0, 0);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("br_full_in_ready", in_ready, 0);
        sb_redir.push_back(32'h400);
        rf_ready = 1'b1;
        step();
        exp_cnt += 1;
        chk("br_redirect_valid", redirect_valid, 1);
        chk("br_redirect_target", redirect_target, 32'h400);
        chk("br_empty_in_ready", in_ready, 1);
        step();
        chk("br_redirect_pulse_end", redirect_valid, 0);
        step();
        chk("br_count", retired_count, 16'(exp_cnt));

        // Taken jump from ONE drops a same-cycle accept
        put(1, 0, 10, 32'h5, 2'b10, 0, 0, 0, 32'h800);
        step();
        put(1, 1, 11, 32'hBB, 2'b00, 0, 0, 0, 0);
        sb_redir.push_back(32'h800);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        exp_cnt += 1;
        chk("jmp_redirect_valid", redirect_valid, 1);
        step();
        step();
        chk("jmp_count", retired_count, 16'(exp_cnt));

        // Flush beats retire and a concurrent accept
        rf_ready = 1'b0;
        put(1, 1, 5, 32'h55, 2'b00, 0, 0, 0, 0);
        step();
        put(1, 1, 6, 32'h66, 2'b00, 0, 0, 0, 0);
        rf_ready = 1'b1;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_count", retired_count, 16'(exp_cnt));
        step();
        step();
        chk("flush_count_later", retired_count, 16'(exp_cnt));

        // Zero-register write is discarded but still counted
        put(1, 1, 0, 32'hDEAD, 2'b00, 0, 0, 0, 0);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step();
        exp_cnt += 1;
        chk("zero_reg_count", retired_count, 16'(exp_cnt));

        // Counter wrap: advance to 0xFFFF, then one more retire
        n = 16'hFFFF - exp_cnt;
        put(1, 0, 7, 32'h7, 2'b00, 0, 0, 0, 0);
        repeat (n) step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step();
        chk("cnt_max", retired_count, 16'hFFFF);
        put(1, 0, 7, 32'h7, 2'b00, 0, 0, 0, 0);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step();
        chk("cnt_wrap", retired_count, 16'h0000);

        // Conditional branch not taken via cond flag writes normally, no redirect
        put(1, 1, 13, 32'h1, 2'b01, 1, 1, 0, 32'hC00);
        expect_wr(13, 32'h1);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step();
        chk("nt_redirect_valid", redirect_valid, 0);
        chk("nt_count", retired_count, 16'h0001);

        // Async reset while FULL, between edges
        rf_ready = 1'b0;
        put(1, 1, 3, 32'h33, 2'b00, 0, 0, 0, 0);
        step();
        put(1, 1, 4, 32'h44, 2'b00, 0, 0, 0, 0);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("pre_rst_rf_addr", rf_addr, 3);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_rf_addr", rf_addr, 0);
        chk("mid_rst_rf_data", rf_data, 0);
        chk("mid_rst_count", retired_count, 0);
        chk("mid_rst_redirect_target", redirect_target, 0);
        reset    = 1'b1;
        rf_ready = 1'b1;
        put(1, 1, 12, 32'h1234, 2'b00, 0, 0, 0, 0);
        expect_wr(12, 32'h1234);
        step();
        put(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        step();
        step();
        chk("post_rst_count", retired_count, 1);

        chk("sb_wr_drained", 64'(sb_wr.size()), 0);
        chk("sb_redir_drained", 64'(sb_redir.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
